// File: rtl/div_sqrt_pack_round.sv
// Back end of the FP32 divide/sqrt unit: normalizes the raw quotient/root, rounds it
// under mode and precision control, and packs it into IEEE-754 single precision with flags.
module div_sqrt_pack_round #(
  parameter int C_DIV_RM   = 2,
  parameter int C_DIV_PC   = 5,
  parameter int C_DIV_MANT = 23,
  parameter int C_DIV_EXP  = 8
) (
  input  logic                Clk_CI,
  input  logic                Rst_RBI,
  input  logic                Flush_SI,
  input  logic                In_valid_SI,
  output logic                In_ready_SO,
  input  logic                Sign_DI,
  input  logic [9:0]          Exp_DI,
  input  logic [25:0]         Mant_DI,
  input  logic                Sticky_SI,
  input  logic [1:0]          Special_SI,
  input  logic [C_DIV_RM-1:0] RM_SI,
  input  logic [C_DIV_PC-1:0] Prec_SI,
  output logic                Out_valid_SO,
  input  logic                Out_ready_SI,
  output logic [31:0]         Result_DO,
  output logic [2:0]          Flags_SO
);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} rm_e;

  localparam int EXP_INF = (1 << C_DIV_EXP) - 1;
  localparam logic [C_DIV_PC-1:0] PREC_MAX = C_DIV_PC'(C_DIV_MANT);
  localparam logic [30:0] MAG_INF = {{C_DIV_EXP{1'b1}}, {C_DIV_MANT{1'b0}}};
  localparam logic [30:0] MAG_MAX = {{(C_DIV_EXP-1){1'b1}}, 1'b0, {C_DIV_MANT{1'b1}}};

  // Stage 1 state (normalized operand)
  logic                v1;
  logic                s1_sign;
  logic signed [10:0]  s1_exp;
  logic [24:0]         s1_frac;
  logic                s1_sticky;
  cls_e                s1_class;
  rm_e                 s1_rm;
  logic [C_DIV_PC-1:0] s1_prec;

  logic v2;
  logic load1, load2;
  logic signed [10:0] exp_in;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign load2        = ~v2 | Out_ready_SI;
  assign load1        = ~v1 | load2;
  assign In_ready_SO  = load1;
  assign Out_valid_SO = v2;
  assign exp_in       = {Exp_DI[9], Exp_DI};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v1        <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_frac   <= '0;
      s1_sticky <= 1'b0;
      s1_class  <= CLS_NORM;
      s1_rm     <= RM_RNE;
      s1_prec   <= '0;
    end else if (Flush_SI) begin
      v1 <= 1'b0;
    end else if (load1) begin
      v1 <= In_valid_SI;
      if (In_valid_SI) begin
        s1_sign   <= Sign_DI;
        s1_exp    <= Mant_DI[25] ? exp_in : exp_in - 11'sd1;
        s1_frac   <= Mant_DI[25] ? Mant_DI[24:0] : {Mant_DI[23:0], 1'b0};
        s1_sticky <= Sticky_SI;
        s1_class  <= cls_e'(Special_SI);
        s1_rm     <= rm_e'(RM_SI);
        s1_prec   <= (Prec_SI > PREC_MAX) ? PREC_MAX : Prec_SI;
      end
    end
  end

  // Stage 2 combinational round and pack
  int                 p;
  logic [24:0]        lower;
  logic [24:0]        g_mask;
  logic               guard, sticky, lsb, round_up, carry;
  logic [23:0]        frac_sum;
  logic signed [10:0] exp_r;
  logic [31:0]        res_d;
  logic [2:0]         flags_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    p        = int'(s1_prec);
    lower    = 25'h1FF_FFFF >> p;           // guard position and everything below it
    g_mask   = 25'h1 << (24 - p);
    guard    = |(s1_frac & g_mask);
    sticky   = (|(s1_frac & (lower >> 1))) | s1_sticky;
    lsb      = (p == 0) ? 1'b1 : |(s1_frac & (g_mask << 1));  // P=0 keeps only the hidden 1
    round_up = 1'b0;
    case (s1_rm)
      RM_RNE: round_up = guard & (sticky | lsb);
      RM_RTZ: round_up = 1'b0;
      RM_RUP: round_up = (guard | sticky) & ~s1_sign;
      RM_RDN: round_up = (guard | sticky) & s1_sign;
      default: round_up = 1'b0;
    endcase
    frac_sum = {1'b0, s1_frac[24:2] & ~lower[24:2]} + ({23'h0, round_up} << (23 - p));
    carry    = frac_sum[23];
    exp_r    = s1_exp + {10'h0, carry};

    res_d   = {s1_sign, exp_r[C_DIV_EXP-1:0], frac_sum[C_DIV_MANT-1:0]};
    flags_d = {2'b00, guard | sticky};
    if (int'(exp_r) >= EXP_INF) begin
      flags_d = 3'b101;
      case (s1_rm)
        RM_RNE:  res_d = {s1_sign, MAG_INF};
        RM_RTZ:  res_d = {s1_sign, MAG_MAX};
        RM_RUP:  res_d = {s1_sign, s1_sign ? MAG_MAX : MAG_INF};
        RM_RDN:  res_d = {s1_sign, s1_sign ? MAG_INF : MAG_MAX};
        default: res_d = {s1_sign, MAG_INF};
      endcase
    end else if (exp_r <= 11'sd0) begin
      flags_d = 3'b011;
      res_d   = {s1_sign, 31'h0};
    end

    // Special classes bypass rounding and raise no flags.
    case (s1_class)
      CLS_ZERO: begin res_d = {s1_sign, 31'h0};   flags_d = 3'b000; end
      CLS_INF:  begin res_d = {s1_sign, MAG_INF}; flags_d = 3'b000; end
      CLS_NAN:  begin res_d = 32'h7FC0_0000;      flags_d = 3'b000; end
      default:  ;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      v2        <= 1'b0;
      Result_DO <= '0;
      Flags_SO  <= '0;
    end else if (Flush_SI) begin
      v2 <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        Result_DO <= res_d;
        Flags_SO  <= flags_d;
      end
    end
  end

endmodule
